// File: rtl/prog_loader.sv
// Serial program loader: parses 0xA5-headed frames into 15-bit instruction-memory writes.
// Optional trailing checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader (
  input  logic        CLK_ip,
  input  logic        RST_ip,
  input  logic [7:0]  BYTE_ip,
  input  logic        BYTE_VALID_ip,
  output logic        BYTE_READY_op,
  output logic        WE_op,
  output logic [12:0] WADDR_op,
  output logic [14:0] WDATA_op,
  output logic        CPU_RST_op,
  output logic        DONE_op,
  output logic        ERR_op
);

  typedef enum logic [3:0] {
    IDLE, CNT_H, CNT_L, DAT_H, DAT_L, WRITE, CSUM, DONE, ERR
  } state_t;

  localparam logic [7:0] HEADER = 8'hA5;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t AFTER_LAST = CSUM;
`else
  localparam state_t AFTER_LAST = DONE;
`endif

  state_t      state_q, state_d;
  logic [12:0] addr_q, addr_d;
  logic [12:0] cnt_q, cnt_d;
  logic [14:0] data_q, data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif
  logic        accept;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_ip or posedge RST_ip) begin
    if (RST_ip) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign accept = BYTE_VALID_ip && (state_q != WRITE);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (accept && BYTE_ip == HEADER) begin
          addr_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = CNT_H;
        end
      end
      CNT_H: begin
        if (accept) begin
          if (BYTE_ip[7:5] != 3'b000) begin
            state_d = ERR;
          end else begin
            cnt_d   = {BYTE_ip[4:0], 8'h00};
            state_d = CNT_L;
          end
        end
      end
      CNT_L: begin
        if (accept) begin
          cnt_d[7:0] = BYTE_ip;
          state_d    = ({cnt_q[12:8], BYTE_ip} == 13'd0) ? AFTER_LAST : DAT_H;
        end
      end
      DAT_H: begin
        if (accept) begin
          data_d[14:8] = BYTE_ip[6:0];
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d       = csum_q + BYTE_ip;
`endif
          state_d      = DAT_L;
        end
      end
      DAT_L: begin
        if (accept) begin
          data_d[7:0] = BYTE_ip;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d      = csum_q + BYTE_ip;
`endif
          state_d     = WRITE;
        end
      end
      WRITE: begin
        // The write itself uses addr_q this cycle; the pointer moves on afterwards.
        addr_d  = addr_q + 13'd1;
        state_d = (addr_q + 13'd1 == cnt_q) ? AFTER_LAST : DAT_H;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) state_d = (BYTE_ip == csum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    WE_op         = (state_q == WRITE);
    BYTE_READY_op = (state_q != WRITE);
    DONE_op       = (state_q == DONE);
    ERR_op        = (state_q == ERR);
    CPU_RST_op    = (state_q != DONE);
    WADDR_op      = addr_q;
    WDATA_op      = data_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; follows PROG_LOADER_CHECKSUM_EN if defined.
module tb_prog_loader;

  logic        CLK_ip = 1'b0;
  logic        RST_ip;
  logic [7:0]  BYTE_ip;
  logic        BYTE_VALID_ip;
  logic        BYTE_READY_op;
  logic        WE_op;
  logic [12:0] WADDR_op;
  logic [14:0] WDATA_op;
  logic        CPU_RST_op;
  logic        DONE_op;
  logic        ERR_op;

  prog_loader dut (
    .CLK_ip        (CLK_ip),
    .RST_ip        (RST_ip),
    .BYTE_ip       (BYTE_ip),
    .BYTE_VALID_ip (BYTE_VALID_ip),
    .BYTE_READY_op (BYTE_READY_op),
    .WE_op         (WE_op),
    .WADDR_op      (WADDR_op),
    .WDATA_op      (WDATA_op),
    .CPU_RST_op    (CPU_RST_op),
    .DONE_op       (DONE_op),
    .ERR_op        (ERR_op)
  );

  always #5 CLK_ip = ~CLK_ip;

  int vectors     = 0;
  int miscompares = 0;
  int we_cnt      = 0;
  int rdy_low_cnt = 0;
  logic [12:0] wa_q[$];
  logic [14:0] wd_q[$];

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge CLK_ip) begin
    if (WE_op) begin
      we_cnt++;
      wa_q.push_back(WADDR_op);
      wd_q.push_back(WDATA_op);
    end
    if (!BYTE_READY_op) rdy_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a byte and returns once it will be taken on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge CLK_ip);
    BYTE_ip       = b;
    BYTE_VALID_ip = 1'b1;
    while (!BYTE_READY_op && n < 20) begin
      @(negedge CLK_ip);
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int cycles);
    @(negedge CLK_ip);
    BYTE_VALID_ip = 1'b0;
    repeat (cycles) @(negedge CLK_ip);
  endtask

  task automatic expect_write(input string tag, input logic [12:0] a, input logic [14:0] d);
    if (wa_q.size() == 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_addr"}, 32'(wa_q.pop_front()), 32'(a));
      check({tag, "_data"}, 32'(wd_q.pop_front()), 32'(d));
    end
  endtask

  task automatic send_good_frame();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h7F); send_byte(8'hFF);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'hA2);
`endif
  endtask

  initial begin
    int we_before;
    RST_ip        = 1'b1;
    BYTE_ip       = 8'h00;
    BYTE_VALID_ip = 1'b0;
    repeat (2) @(negedge CLK_ip);
    check("rst_ready",   BYTE_READY_op, 1);
    check("rst_we",      WE_op, 0);
    check("rst_waddr",   WADDR_op, 0);
    check("rst_wdata",   WDATA_op, 0);
    check("rst_done",    DONE_op, 0);
    check("rst_err",     ERR_op, 0);
    check("rst_cpu_rst", CPU_RST_op, 1);
    RST_ip = 1'b0;

    // Two-word good frame.
    send_good_frame();
    idle(3);
    expect_write("good_w0", 13'd0, 15'h0123);
    expect_write("good_w1", 13'd1, 15'h7FFF);
    check("good_we_cnt",  we_cnt, 2);
    check("good_done",    DONE_op, 1);
    check("good_err",     ERR_op, 0);
    check("good_cpu_rst", CPU_RST_op, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Same frame, wrong checksum.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h7F); send_byte(8'hFF);
    send_byte(8'h00);
    idle(3);
    expect_write("bad_w0", 13'd0, 15'h0123);
    expect_write("bad_w1", 13'd1, 15'h7FFF);
    check("bad_err",     ERR_op, 1);
    check("bad_done",    DONE_op, 0);
    check("bad_cpu_rst", CPU_RST_op, 1);
`endif

    // Junk byte dropped, then illegal count high.
    we_before = we_cnt;
    send_byte(8'h11); send_byte(8'hA5); send_byte(8'h20);
    idle(3);
    check("cnt_err",     ERR_op, 1);
    check("cnt_done",    DONE_op, 0);
    check("cnt_cpu_rst", CPU_RST_op, 1);
    check("cnt_no_we",   we_cnt, we_before);

    // Zero-length frame.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    idle(2);
    check("zero_done", DONE_op, 1);
    check("zero_err",  ERR_op, 0);
    check("zero_no_we", we_cnt, we_before);

    // Reset in the middle of a three-word frame.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h23);
    idle(2);
    expect_write("mid_w0", 13'd0, 15'h0123);
    @(negedge CLK_ip);
    RST_ip = 1'b1;
    #1;
    check("mid_rst_cpu",   CPU_RST_op, 1);
    check("mid_rst_waddr", WADDR_op, 0);
    check("mid_rst_wdata", WDATA_op, 0);
    check("mid_rst_ready", BYTE_READY_op, 1);
    @(negedge CLK_ip);
    RST_ip = 1'b0;
    we_before = we_cnt;
    send_byte(8'h45); send_byte(8'h67);
    idle(3);
    check("post_rst_no_we", we_cnt, we_before);
    check("post_rst_done",  DONE_op, 0);
    check("post_rst_cpu",   CPU_RST_op, 1);
    send_good_frame();
    idle(3);
    expect_write("reload_w0", 13'd0, 15'h0123);
    expect_write("reload_w1", 13'd1, 15'h7FFF);
    check("reload_done", DONE_op, 1);

    // Continuous valid; 0xA5 as data, high-byte bit 7 dropped from the word.
    we_before   = we_cnt;
    rdy_low_cnt = 0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'hA5); send_byte(8'hA5);
    send_byte(8'h80); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h11);
`endif
    idle(3);
    expect_write("strm_w0", 13'd0, 15'h25A5);
    expect_write("strm_w1", 13'd1, 15'h0001);
    expect_write("strm_w2", 13'd2, 15'h1234);
    check("strm_we_cnt",  we_cnt - we_before, 3);
    check("strm_rdy_low", rdy_low_cnt, 3);
    check("strm_done",    DONE_op, 1);
    check("strm_extra",   wa_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
